// File: rtl/amba3_axi_slave_ram.sv
// rtl/amba3_axi_slave_ram.sv - AXI3 slave backed by an on-chip word-addressed RAM
module amba3_axi_slave_ram #(
    parameter int TXID_SIZE = 4,
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 128,
    parameter int MEM_DEPTH = 256
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [TXID_SIZE-1:0]   awid,
    input  logic [ADDR_SIZE-1:0]   awaddr,
    input  logic [3:0]             awlen,
    input  logic [2:0]             awsize,
    input  logic [1:0]             awburst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [TXID_SIZE-1:0]   wid,
    input  logic [DATA_SIZE-1:0]   wdata,
    input  logic [DATA_SIZE/8-1:0] wstrb,
    input  logic                   wlast,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [TXID_SIZE-1:0]   bid,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [TXID_SIZE-1:0]   arid,
    input  logic [ADDR_SIZE-1:0]   araddr,
    input  logic [3:0]             arlen,
    input  logic [2:0]             arsize,
    input  logic [1:0]             arburst,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [TXID_SIZE-1:0]   rid,
    output logic [DATA_SIZE-1:0]   rdata,
    output logic [1:0]             rresp,
    output logic                   rlast,
    output logic                   rvalid,
    input  logic                   rready
);
    localparam int NB = DATA_SIZE / 8;
    localparam int NB_LOG = $clog2(NB);
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam logic [2:0] MAX_SIZE = 3'(NB_LOG);
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a,
            input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_SIZE-1:0] step;
        logic [ADDR_SIZE-1:0] wmask;
        logic [ADDR_SIZE-1:0] nxt;
        step  = ADDR_SIZE'(1) << size;
        wmask = ((ADDR_SIZE'(len) + ADDR_SIZE'(1)) << size) - ADDR_SIZE'(1);
        case (burst)
            2'b00:   nxt = a;
            2'b10:   nxt = (a & ~wmask) | ((a + step) & wmask);
            default: nxt = a + step;
        endcase
        return nxt;
    endfunction

    function automatic logic burst_err(input logic [ADDR_SIZE-1:0] a,
            input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic bad_wrap;
        bad_wrap = (burst == 2'b10) &&
                   (!(len inside {4'd1, 4'd3, 4'd7, 4'd15}) ||
                    ((a & ((ADDR_SIZE'(1) << size) - ADDR_SIZE'(1))) != '0));
        return (burst == 2'b11) || (size > MAX_SIZE) || bad_wrap;
    endfunction

    // Holds both address channels off until one clean cycle after reset release
    logic rst_done;
    always_ff @(posedge aclk) begin
        rst_done <= !areset;
    end

    logic unused_wid;
    assign unused_wid = ^wid;

    // Write channel
    w_state_t             w_state, w_next;
    logic [ADDR_SIZE-1:0] w_addr;
    logic [3:0]           w_len, w_cnt;
    logic [2:0]           w_size;
    logic [1:0]           w_burst;
    logic                 w_aerr;
    logic                 aw_hs, w_hs;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            bid     <= '0;
            bresp   <= 2'b00;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_aerr  <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                bid     <= awid;
                w_addr  <= awaddr;
                w_len   <= awlen;
                w_size  <= awsize;
                w_burst <= awburst;
                w_cnt   <= '0;
                w_aerr  <= burst_err(awaddr, awlen, awsize, awburst);
                bresp   <= burst_err(awaddr, awlen, awsize, awburst) ? SLVERR : 2'b00;
            end
            if (w_hs) begin
                w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                w_cnt  <= w_cnt + 4'd1;
                if (wlast != (w_cnt == w_len))
                    bresp <= SLVERR;
            end
        end
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = rst_done;
                if (awvalid && rst_done)
                    w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && (w_cnt == w_len))
                    w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready)
                    w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Address-error bursts still consume their beats but never touch the array
    always_ff @(posedge aclk) begin
        if (w_hs && !w_aerr && !areset) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb[i])
                    mem[w_addr[NB_LOG +: MEM_AW]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read channel
    r_state_t             r_state, r_next;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [3:0]           r_len, r_cnt;
    logic [2:0]           r_size;
    logic [1:0]           r_burst;
    logic                 r_aerr;
    logic                 ar_hs, r_hs;

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= R_IDLE;
            rid     <= '0;
            rresp   <= 2'b00;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_aerr  <= 1'b0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                rid     <= arid;
                r_addr  <= araddr;
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= arburst;
                r_cnt   <= '0;
                r_aerr  <= burst_err(araddr, arlen, arsize, arburst);
                rresp   <= burst_err(araddr, arlen, arsize, arburst) ? SLVERR : 2'b00;
            end
            if (r_hs) begin
                r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
                r_cnt  <= r_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rdata   = '0;
        case (r_state)
            R_IDLE: begin
                arready = rst_done;
                if (arvalid && rst_done)
                    r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (r_cnt == r_len);
                rdata  = r_aerr ? '0 : mem[r_addr[NB_LOG +: MEM_AW]];
                if (rready && (r_cnt == r_len))
                    r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end
endmodule

// File: tb/tb_amba3_axi_slave_ram.sv
// tb/tb_amba3_axi_slave_ram.sv - directed self-checking bench for amba3_axi_slave_ram
module tb_amba3_axi_slave_ram;
    localparam int DW = 128;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [3:0]    awid = '0, wid = '0, arid = '0;
    logic [31:0]   awaddr = '0, araddr = '0;
    logic [3:0]    awlen = '0, arlen = '0;
    logic [2:0]    awsize = '0, arsize = '0;
    logic [1:0]    awburst = '0, arburst = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
    logic          arvalid = 1'b0, rready = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [15:0]   wstrb = '0;
    logic          awready, wready, bvalid, arready, rvalid, rlast;
    logic [3:0]    bid, rid;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;

    always #5 aclk = ~aclk;

    amba3_axi_slave_ram dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] wd [16];
    logic [15:0]   ws [16];
    logic [DW-1:0] rd [16];
    logic [1:0]    rr [16];
    logic          rl [16];
    logic [3:0]    ri [16];
    int            nr;
    logic [1:0]    b_resp;
    logic [3:0]    b_id;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called and returns at posedge+1
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input bit bad_last, input bit hold_b);
        int t;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd4; awburst = burst; awvalid = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!awready && t < 50) begin t++; @(negedge aclk); end
        if (t >= 50) check_eq("aw_timeout", 0, 1);
        @(posedge aclk); #1 awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = bad_last ? 1'b1 : (i == int'(len)); wvalid = 1'b1;
            t = 0;
            @(negedge aclk);
            while (!wready && t < 50) begin t++; @(negedge aclk); end
            if (t >= 50) check_eq("w_timeout", 0, 1);
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge aclk);
        check_eq("bvalid_after_last", bvalid, 1);
        check_eq("wready_after_last", wready, 0);
        if (hold_b) begin
            for (int k = 0; k < 5; k++) begin
                check_eq("bvalid_held", bvalid, 1);
                check_eq("bid_held", bid, id);
                @(negedge aclk);
            end
        end
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 50) begin t++; @(negedge aclk); end
        if (t >= 50) check_eq("b_timeout", 0, 1);
        b_resp = bresp; b_id = bid;
        @(posedge aclk); #1 bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input bit toggle);
        int t;
        arid = id; araddr = addr; arlen = len; arsize = 3'd4; arburst = burst; arvalid = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!arready && t < 50) begin t++; @(negedge aclk); end
        if (t >= 50) check_eq("ar_timeout", 0, 1);
        @(posedge aclk); #1 arvalid = 1'b0;
        nr = 0; t = 0;
        rready = 1'b0;
        while (nr <= int'(len) && t < 100) begin
            rready = toggle ? ~rready : 1'b1;
            @(negedge aclk);
            if (rvalid && rready) begin
                rd[nr] = rdata; rr[nr] = rresp; rl[nr] = rlast; ri[nr] = rid;
                nr++;
            end
            t++;
            @(posedge aclk); #1;
        end
        rready = 1'b0;
        if (t >= 100) check_eq("r_timeout", 0, 1);
        @(negedge aclk);
        check_eq("rvalid_after_last", rvalid, 0);
        check_eq("arready_after_last", arready, 1);
        @(posedge aclk); #1;
    endtask

    task automatic check_read(input string tag, input logic [3:0] id, input int beats,
                              input logic [1:0] resp);
        check_eq({tag, "_beats"}, nr, beats);
        for (int i = 0; i < beats; i++) begin
            check_eq({tag, "_rlast"}, rl[i], (i == beats - 1));
            check_eq({tag, "_rresp"}, rr[i], resp);
            check_eq({tag, "_rid"}, ri[i], id);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 16'hFFFF; end
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_awready", awready, 0);
        check_eq("rst_arready", arready, 0);
        check_eq("rst_wready", wready, 0);
        check_eq("rst_bvalid", bvalid, 0);
        check_eq("rst_rvalid", rvalid, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_ids", {bid, rid, bresp, rresp, rlast}, 0);
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        check_eq("awready_before_edge", awready, 0);
        @(negedge aclk);
        check_eq("awready_after_rst", awready, 1);
        check_eq("arready_after_rst", arready, 1);
        @(posedge aclk); #1;

        // INCR write then read back
        for (int i = 0; i < 4; i++) wd[i] = DW'(8'h11 + i);
        axi_write(4'd5, 32'h10, 4'd3, 2'b01, 1'b0, 1'b0);
        check_eq("incr_bresp", b_resp, 2'b00);
        check_eq("incr_bid", b_id, 4'd5);
        axi_read(4'd6, 32'h10, 4'd3, 2'b01, 1'b0);
        check_read("incr", 4'd6, 4, 2'b00);
        for (int i = 0; i < 4; i++) check_eq("incr_rdata", rd[i], DW'(8'h11 + i));

        // WRAP read starting at word 3 of a 4-word window
        for (int i = 0; i < 4; i++) wd[i] = DW'(8'hA0 + i);
        axi_write(4'd1, 32'h0, 4'd3, 2'b01, 1'b0, 1'b0);
        axi_read(4'd2, 32'h30, 4'd3, 2'b10, 1'b0);
        check_read("wrap", 4'd2, 4, 2'b00);
        check_eq("wrap_b0", rd[0], DW'(8'hA3));
        check_eq("wrap_b1", rd[1], DW'(8'hA0));
        check_eq("wrap_b2", rd[2], DW'(8'hA1));
        check_eq("wrap_b3", rd[3], DW'(8'hA2));

        // Partial strobe
        wd[0] = '1;
        axi_write(4'd0, 32'h40, 4'd0, 2'b01, 1'b0, 1'b0);
        wd[0] = '0; ws[0] = 16'h0001;
        axi_write(4'd0, 32'h40, 4'd0, 2'b01, 1'b0, 1'b0);
        ws[0] = 16'hFFFF;
        axi_read(4'd0, 32'h40, 4'd0, 2'b01, 1'b0);
        check_eq("strobe_rdata", rd[0], {{(DW-8){1'b1}}, 8'h00});

        // Reserved burst type: beats accepted, no write
        wd[0] = DW'(8'h55);
        axi_write(4'd0, 32'h50, 4'd0, 2'b01, 1'b0, 1'b0);
        wd[0] = DW'(8'h99); wd[1] = DW'(8'h99);
        axi_write(4'd7, 32'h50, 4'd1, 2'b11, 1'b0, 1'b0);
        check_eq("badburst_bresp", b_resp, 2'b10);
        axi_read(4'd0, 32'h50, 4'd0, 2'b01, 1'b0);
        check_eq("badburst_unchanged", rd[0], DW'(8'h55));

        // WRAP with illegal length
        axi_read(4'd3, 32'h0, 4'd2, 2'b10, 1'b0);
        check_read("badwrap", 4'd3, 3, 2'b10);
        for (int i = 0; i < 3; i++) check_eq("badwrap_rdata", rd[i], 0);

        // wlast early: error response, data still written
        wd[0] = DW'(8'h77); wd[1] = DW'(8'h78);
        axi_write(4'd4, 32'h60, 4'd1, 2'b01, 1'b1, 1'b0);
        check_eq("wlast_bresp", b_resp, 2'b10);
        axi_read(4'd4, 32'h60, 4'd1, 2'b01, 1'b0);
        check_eq("wlast_b0", rd[0], DW'(8'h77));
        check_eq("wlast_b1", rd[1], DW'(8'h78));

        // B backpressure
        wd[0] = DW'(8'h70);
        axi_write(4'd9, 32'h70, 4'd0, 2'b01, 1'b0, 1'b1);
        check_eq("bp_bresp", b_resp, 2'b00);
        check_eq("bp_bid", b_id, 4'd9);

        // R backpressure with toggling rready
        for (int i = 0; i < 8; i++) wd[i] = DW'(8'h80 + i);
        axi_write(4'd2, 32'h80, 4'd7, 2'b01, 1'b0, 1'b0);
        axi_read(4'd8, 32'h80, 4'd7, 2'b01, 1'b1);
        check_read("toggle", 4'd8, 8, 2'b00);
        for (int i = 0; i < 8; i++) check_eq("toggle_rdata", rd[i], DW'(8'h80 + i));

        // Concurrent write and read
        wd[0] = DW'(8'hC0);
        fork
            axi_write(4'd3, 32'h100, 4'd0, 2'b01, 1'b0, 1'b0);
            axi_read(4'd4, 32'h10, 4'd0, 2'b01, 1'b0);
        join
        check_eq("conc_bresp", b_resp, 2'b00);
        check_eq("conc_rdata", rd[0], DW'(8'hA1));
        axi_read(4'd4, 32'h100, 4'd0, 2'b01, 1'b0);
        check_eq("conc_written", rd[0], DW'(8'hC0));

        // Reset during beat 2 of a len=7 read
        arid = 4'd5; araddr = 32'h80; arlen = 4'd7; arsize = 3'd4; arburst = 2'b01; arvalid = 1'b1;
        @(negedge aclk);
        check_eq("rstrd_arready", arready, 1);
        @(posedge aclk); #1 arvalid = 1'b0; rready = 1'b1;
        @(negedge aclk);
        check_eq("rstrd_beat0", rdata, DW'(8'h80));
        @(posedge aclk); #1;
        @(negedge aclk);
        check_eq("rstrd_beat1", rdata, DW'(8'h81));
        @(posedge aclk); #1 areset = 1'b1;
        @(negedge aclk);
        check_eq("rstrd_beat2_vis", rvalid, 1);
        @(posedge aclk); #1;
        @(negedge aclk);
        check_eq("rstrd_rvalid", rvalid, 0);
        check_eq("rstrd_rdata", rdata, 0);
        @(posedge aclk); #1 areset = 1'b0; rready = 1'b0;
        @(negedge aclk);
        check_eq("rstrd_arready_low", arready, 0);
        @(negedge aclk);
        check_eq("rstrd_arready_high", arready, 1);
        @(posedge aclk); #1;
        axi_read(4'd6, 32'h80, 4'd0, 2'b01, 1'b0);
        check_eq("ram_kept", rd[0], DW'(8'h80));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
